// File: rtl/bitonic_merge_pipe_if.sv
// bitonic_merge_pipe_if: valid/ready input and output sides of the bitonic merge pipe
interface bitonic_merge_pipe_if #(parameter int W = 16, parameter int LOG_N = 3);
  localparam int N = 1 << LOG_N;
  logic         in_valid;
  logic         in_ready;
  logic         direction;
  logic [N*W-1:0] IN;
  logic         out_valid;
  logic         out_ready;
  logic [N*W-1:0] OUT;
  logic         out_dir;
  logic [6:0]   occupancy;
  modport master (output in_valid, direction, IN, out_ready,
                  input in_ready, out_valid, OUT, out_dir, occupancy);
  modport slave  (input in_valid, direction, IN, out_ready,
                  output in_ready, out_valid, OUT, out_dir, occupancy);
endinterface

// File: rtl/bitonic_merge_pipe.sv
// bitonic_merge_pipe: LOG_N registered half-cleaner layers merging a bitonic sequence into sorted order
module bitonic_merge_pipe #(
  parameter int W     = 16,
  parameter int LOG_N = 3
) (
  input logic clk,
  input logic rst,
  bitonic_merge_pipe_if.slave bus
);
  localparam int N = 1 << LOG_N;
  logic [N*W-1:0] data_q [LOG_N];
  logic [N*W-1:0] lay    [LOG_N];
  logic [LOG_N-1:0] valid_q, valid_d, dir_q, dir_d;
  logic [6:0] occ_q;
  logic [W-1:0] a, b;
  logic sd, swap, adv;
  assign adv     = ~valid_q[LOG_N-1] | bus.out_ready;
  assign valid_d = (valid_q << 1) | LOG_N'(bus.in_valid);
  assign dir_d   = (dir_q << 1) | LOG_N'(bus.direction);
  // Pairs within a layer are disjoint, so each layer swaps in place on its own copy.
  always_comb begin
    a    = '0;
    b    = '0;
    sd   = 1'b0;
    swap = 1'b0;
    for (int s = 0; s < LOG_N; s++) begin
      lay[s] = s == 0 ? bus.IN : data_q[(s + LOG_N - 1) % LOG_N];
      sd     = s == 0 ? bus.direction : dir_q[(s + LOG_N - 1) % LOG_N];
      for (int i = 0; i < N; i++) begin
        if ((i & (N >> (s + 1))) == 0) begin
          a    = lay[s][i*W +: W];
          b    = lay[s][(i + (N >> (s + 1)))*W +: W];
          swap = sd ? a < b : a > b;
          lay[s][i*W +: W]                    = swap ? b : a;
          lay[s][(i + (N >> (s + 1)))*W +: W] = swap ? a : b;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dir_q   <= '0;
      occ_q   <= '0;
      for (int s = 0; s < LOG_N; s++) data_q[s] <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
      dir_q   <= dir_d;
      occ_q   <= 7'($countones(valid_d));
      for (int s = 0; s < LOG_N; s++) data_q[s] <= lay[s];
    end
  end
  assign bus.in_ready  = adv & ~rst;
  assign bus.out_valid = valid_q[LOG_N-1];
  assign bus.out_dir   = dir_q[LOG_N-1];
  assign bus.OUT       = data_q[LOG_N-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// tb_bitonic_merge_pipe: random bitonic traffic against a sort-based scoreboard, plus directed cases
module tb_bitonic_merge_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitonic_merge_pipe_if #(.W(16), .LOG_N(3)) bus ();
  bitonic_merge_pipe #(.W(16), .LOG_N(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  bitonic_merge_pipe_if #(.W(8), .LOG_N(1)) bus2 ();
  bitonic_merge_pipe #(.W(8), .LOG_N(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0, bad = 0;
  int inflight = 0, cyc = 0, pop_cyc = -1, npop = 0;
  logic acc;
  logic [127:0] last_out, saved;
  logic last_dir;
  logic [128:0] exp_q[$];

  localparam logic [127:0] K_IN   = {16'd2, 16'd4, 16'd6, 16'd8, 16'd7, 16'd5, 16'd3, 16'd1};
  localparam logic [127:0] K_ASC  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [127:0] K_DESC = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
  localparam logic [127:0] K_FIVE = {8{16'd5}};
  localparam logic [127:0] K_TOP  = {{7{16'd0}}, 16'hFFFF};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_sort(input logic [127:0] d, input logic dir);
    int k[8];
    int t;
    logic [127:0] r;
    for (int i = 0; i < 8; i++) k[i] = int'(d[i*16 +: 16]);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (dir ? k[j] < k[j+1] : k[j] > k[j+1]) begin
          t = k[j]; k[j] = k[j+1]; k[j+1] = t;
        end
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(k[i]);
    return r;
  endfunction

  // Ascending run followed by a descending run, then cyclically rotated: always bitonic.
  function automatic logic [127:0] rand_bitonic();
    logic [127:0] d, s, r;
    int seq[8];
    int f = 0, bk = 7, rot;
    logic narrow = ($urandom_range(3) == 0);
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(narrow ? $urandom_range(3) : $urandom_range(65535));
    s = ref_sort(d, 1'b0);
    for (int i = 0; i < 8; i++)
      if ($urandom_range(1) == 1) seq[f++] = int'(s[i*16 +: 16]);
      else seq[bk--] = int'(s[i*16 +: 16]);
    rot = $urandom_range(7);
    for (int i = 0; i < 8; i++) r[((i + rot) % 8)*16 +: 16] = 16'(seq[i]);
    return r;
  endfunction

  task automatic step(input logic iv, input logic dir, input logic [127:0] data, input logic ordy);
    logic [128:0] e;
    @(negedge clk);
    if (!rst) chk("occupancy", bus.occupancy, 128'(inflight));
    bus.in_valid  = iv;
    bus.direction = dir;
    bus.IN        = iv ? data : 'x;
    bus.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (rst) begin
      chk("rst_in_ready", bus.in_ready, 0);
      exp_q.delete();
      inflight = 0;
    end else begin
      if (bus.out_valid && ordy) begin
        if (exp_q.size() == 0) chk("spurious_out", bus.out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", bus.OUT, e[127:0]);
          chk("out_dir", bus.out_dir, e[128]);
        end
        last_out = bus.OUT;
        last_dir = bus.out_dir;
        pop_cyc  = cyc;
        npop++;
        inflight--;
      end
      if (iv && bus.in_ready) begin
        exp_q.push_back({dir, ref_sort(data, dir)});
        inflight++;
        acc = 1'b1;
      end
    end
    cyc++;
  endtask

  initial begin
    int c0, sent, np0;
    logic [127:0] cur;
    logic cdir;
    bus.in_valid = 0; bus.direction = 0; bus.IN = '0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.direction = 0; bus2.IN = '0; bus2.out_ready = 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(0, 0, '0, 1);
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_out", bus.OUT, 0);
    chk("init_in_ready", bus.in_ready, 1);

    // Degenerate 2-key network: one layer, one cycle of latency
    @(negedge clk);
    bus2.in_valid = 1; bus2.direction = 0; bus2.IN = 16'h1090;
    @(negedge clk);
    bus2.direction = 1;
    chk("n2_valid", bus2.out_valid, 1);
    chk("n2_asc", bus2.OUT, 16'h9010);
    chk("n2_asc_dir", bus2.out_dir, 0);
    @(negedge clk);
    bus2.in_valid = 0;
    chk("n2_desc", bus2.OUT, 16'h1090);
    chk("n2_desc_dir", bus2.out_dir, 1);

    c0 = cyc;
    step(1, 0, K_IN, 1);
    repeat (3) step(0, 0, '0, 1);
    chk("asc_latency", 128'(pop_cyc), 128'(c0 + 3));
    chk("asc", last_out, K_ASC);
    chk("asc_dir", last_dir, 0);
    c0 = cyc;
    step(1, 1, K_IN, 1);
    repeat (3) step(0, 0, '0, 1);
    chk("desc_latency", 128'(pop_cyc), 128'(c0 + 3));
    chk("desc", last_out, K_DESC);
    chk("desc_dir", last_dir, 1);

    step(1, 0, K_FIVE, 1);
    step(1, 1, K_FIVE, 1);
    step(1, 0, K_TOP, 1);
    step(1, 1, K_TOP, 1);
    repeat (4) step(0, 0, '0, 1);
    chk("top_desc", last_out, {{7{16'd0}}, 16'hFFFF});

    repeat (3) step(1, 0, K_IN, 0);
    step(0, 0, '0, 0);
    chk("pre_rst_occ", bus.occupancy, 3);
    rst = 1'b1;
    repeat (2) step(0, 0, '0, 0);
    rst = 1'b0;
    step(0, 0, '0, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out", bus.OUT, 0);
    chk("rst_out_dir", bus.out_dir, 0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    sent = 0;
    np0  = npop;
    cur  = rand_bitonic();
    cdir = 1'(($urandom_range(1)));
    for (int j = 0; j < 16; j++) begin
      step(sent < 6, cdir, cur, !(j >= 4 && j < 8));
      if (acc) begin
        sent++;
        cur  = rand_bitonic();
        cdir = 1'(($urandom_range(1)));
      end
      if (j >= 4 && j < 8) chk("bp_in_ready", bus.in_ready, 0);
      if (j == 4) saved = bus.OUT;
      if (j > 4 && j < 8) chk("bp_frozen", bus.OUT, saved);
    end
    repeat (4) step(0, 0, '0, 1);
    chk("bp_count", 128'(npop - np0), 6);

    for (int j = 0; j < 10000; j++)
      step($urandom_range(3) != 0, 1'(($urandom_range(1))), rand_bitonic(), $urandom_range(3) != 0);
    repeat (8) step(0, 0, '0, 1);
    chk("drain_empty", 128'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
